// File: rtl/tensor_pkg.sv
// Shared constants, mode encodings and FSM state type for the packed-integer tensor unit.
package tensor_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned DATA_W = LANES * LANE_W;
    localparam int unsigned IDX_W  = $clog2(LANES);
    localparam int unsigned PROD_W = 2 * LANE_W;

    localparam logic [2:0] TMODE_VADD = 3'b000;
    localparam logic [2:0] TMODE_VSUB = 3'b001;
    localparam logic [2:0] TMODE_VMUL = 3'b010;
    localparam logic [2:0] TMODE_VFMA = 3'b011;
    localparam logic [2:0] TMODE_DOT  = 3'b100;
    localparam logic [2:0] TMODE_VMAX = 3'b101;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFinish = 2'd2
    } tstate_e;

    function automatic logic [LANE_W-1:0] relu_lane(input logic en, input logic [LANE_W-1:0] v);
        return (en && v[LANE_W-1]) ? '0 : v;
    endfunction

endpackage

// File: rtl/tensor_lane_alu.sv
// Combinational single-lane ALU for the tensor unit; lane clamping is built in only when
// TENSOR_SATURATE_EN is defined, otherwise lanes wrap and o_sat is 0.
module tensor_lane_alu
    import tensor_pkg::*;
(
    input  logic [2:0]        i_mode,
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic [LANE_W-1:0] i_c,
    output logic [LANE_W-1:0] o_lane,
    output logic [PROD_W-1:0] o_prod,
    output logic              o_sat
);

    localparam int unsigned WIDE_W = PROD_W + 1;

    logic [PROD_W-1:0] w_prod;
    logic [WIDE_W-1:0] w_wide;

    function automatic logic [WIDE_W-1:0] sx(input logic [LANE_W-1:0] v);
        return {{(WIDE_W - LANE_W){v[LANE_W-1]}}, v};
    endfunction

    // Exact signed product always fits in PROD_W bits.
    assign w_prod = $signed({{LANE_W{i_a[LANE_W-1]}}, i_a}) * $signed({{LANE_W{i_b[LANE_W-1]}}, i_b});
    assign o_prod = w_prod;

    always_comb begin
        w_wide = '0;
        case (i_mode)
            TMODE_VADD: w_wide = sx(i_a) + sx(i_b);
            TMODE_VSUB: w_wide = sx(i_a) - sx(i_b);
            TMODE_VMUL: w_wide = {w_prod[PROD_W-1], w_prod};
            TMODE_VFMA: w_wide = {w_prod[PROD_W-1], w_prod} + sx(i_c);
            TMODE_VMAX: w_wide = ($signed(i_a) > $signed(i_b)) ? sx(i_a) : sx(i_b);
            default:    w_wide = '0;
        endcase
    end

`ifdef TENSOR_SATURATE_EN
    logic w_lane_mode;
    logic w_ovf;

    assign w_lane_mode = (i_mode <= TMODE_VFMA);
    // Overflow when the bits above the lane's sign bit are not a pure sign extension.
    assign w_ovf  = w_lane_mode &&
                    !((&w_wide[WIDE_W-1:LANE_W-1]) || (~|w_wide[WIDE_W-1:LANE_W-1]));
    assign o_lane = w_ovf ? {w_wide[WIDE_W-1], {(LANE_W - 1){~w_wide[WIDE_W-1]}}}
                          : w_wide[LANE_W-1:0];
    assign o_sat  = w_ovf;
`else
    logic w_unused_hi;

    assign w_unused_hi = ^w_wide[WIDE_W-1:LANE_W];
    assign o_lane      = w_wide[LANE_W-1:0];
    assign o_sat       = 1'b0;
`endif

endmodule

// File: rtl/tensor_unit.sv
// Multi-cycle packed-integer vector engine: one shared lane ALU walks LANES lanes, one per cycle.
// Saturating lane arithmetic is selected by TENSOR_SATURATE_EN inside tensor_lane_alu.
module tensor_unit
    import tensor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op_mode,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] opnd_a,
    input  logic [DATA_W-1:0] opnd_b,
    input  logic [DATA_W-1:0] opnd_c,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              busy,
    output logic              sat_flag
);

    tstate_e           r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [2:0]        r_mode;
    logic              r_relu;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_c;
    logic [DATA_W-1:0] r_work;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic              r_done;
    logic              r_busy;
    logic              r_sat;

    logic [LANE_W-1:0] w_a_lane;
    logic [LANE_W-1:0] w_b_lane;
    logic [LANE_W-1:0] w_c_lane;
    logic [LANE_W-1:0] w_lane;
    logic [PROD_W-1:0] w_prod;
    logic              w_sat;
    logic              w_last;
    logic [DATA_W-1:0] w_seed;
    logic [DATA_W-1:0] w_acc_next;
    logic [DATA_W-1:0] w_final;

    assign w_a_lane = r_a[r_idx*LANE_W +: LANE_W];
    assign w_b_lane = r_b[r_idx*LANE_W +: LANE_W];
    assign w_c_lane = r_c[r_idx*LANE_W +: LANE_W];
    assign w_last   = (r_idx == IDX_W'(LANES - 1));

    tensor_lane_alu u_alu (
        .i_mode (r_mode),
        .i_a    (w_a_lane),
        .i_b    (w_b_lane),
        .i_c    (w_c_lane),
        .o_lane (w_lane),
        .o_prod (w_prod),
        .o_sat  (w_sat)
    );

    // Lane 0 also folds in the C lane-0 seed so DOT needs no extra cycle.
    assign w_seed     = (r_idx == '0) ? {{(DATA_W - LANE_W){r_c[LANE_W-1]}}, r_c[LANE_W-1:0]} : '0;
    assign w_acc_next = r_acc + {{(DATA_W - PROD_W){w_prod[PROD_W-1]}}, w_prod} + w_seed;
    assign w_final    = (r_mode == TMODE_DOT) ? ((r_relu && r_acc[DATA_W-1]) ? '0 : r_acc)
                                              : r_work;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_idx    <= '0;
            r_mode   <= '0;
            r_relu   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_work   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_busy <= start;
                    if (start) begin
                        r_mode  <= op_mode;
                        r_relu  <= relu_en;
                        r_a     <= opnd_a;
                        r_b     <= opnd_b;
                        r_c     <= opnd_c;
                        r_work  <= '0;
                        r_acc   <= '0;
                        r_sat   <= 1'b0;
                        r_idx   <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_work[r_idx*LANE_W +: LANE_W] <= relu_lane(r_relu, w_lane);
                    if (r_mode == TMODE_DOT) begin
                        r_acc <= w_acc_next;
                    end
                    r_sat <= r_sat | w_sat;
                    if (w_last) begin
                        r_state <= StFinish;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                StFinish: begin
                    r_result <= w_final;
                    r_done   <= 1'b1;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign result   = r_result;
    assign done     = r_done;
    assign busy     = r_busy;
    assign sat_flag = r_sat;

endmodule

// File: tb/tb_tensor_unit.sv
// Self-checking bench for tensor_unit: directed vector table, hand sequences, random vs model.
module tb_tensor_unit;
    import tensor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op_mode;
    logic        relu_en;
    logic [63:0] opnd_a;
    logic [63:0] opnd_b;
    logic [63:0] opnd_c;
    logic [63:0] result;
    logic        done;
    logic        busy;
    logic        sat_flag;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tensor_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_mode  (op_mode),
        .relu_en  (relu_en),
        .opnd_a   (opnd_a),
        .opnd_b   (opnd_b),
        .opnd_c   (opnd_c),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .sat_flag (sat_flag)
    );

    typedef struct {
        string       name;
        logic [2:0]  mode;
        logic        relu;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] exp;
        logic        sat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    // Reference: signed integer arithmetic per lane, then wrap or clamp into 16 bits.
    function automatic logic [63:0] model(input logic [2:0] m, input logic rl, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] c,
                                          output logic sf);
        longint      dot;
        int          av, bv, cv, v;
        logic [15:0] ln;
        logic [63:0] r;
        sf  = 1'b0;
        r   = '0;
        dot = longint'($signed(c[15:0]));
        for (int i = 0; i < 4; i++) begin
            av = int'($signed(a[i*16 +: 16]));
            bv = int'($signed(b[i*16 +: 16]));
            cv = int'($signed(c[i*16 +: 16]));
            case (m)
                3'd0:    v = av + bv;
                3'd1:    v = av - bv;
                3'd2:    v = av * bv;
                3'd3:    v = av * bv + cv;
                3'd5:    v = (av > bv) ? av : bv;
                default: v = 0;
            endcase
            if (m == 3'd4) dot += longint'(av * bv);
`ifdef TENSOR_SATURATE_EN
            if (m <= 3'd3 && v > 32767) begin
                v  = 32767;
                sf = 1'b1;
            end else if (m <= 3'd3 && v < -32768) begin
                v  = -32768;
                sf = 1'b1;
            end
`endif
            ln = v[15:0];
            if (rl && ln[15]) ln = '0;
            r[i*16 +: 16] = ln;
        end
        if (m == 3'd4) r = (rl && dot < 0) ? 64'd0 : 64'(dot);
        return r;
    endfunction

    function automatic logic [63:0] rand_opnd();
        logic [63:0] v;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 7))
                0:       v[i*16 +: 16] = 16'h7FFF;
                1:       v[i*16 +: 16] = 16'h8000;
                2:       v[i*16 +: 16] = 16'hFFFF;
                3:       v[i*16 +: 16] = 16'h0001;
                default: v[i*16 +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // Launch one op, then watch a fixed window; inj1/inj2 pulse extra starts at those cycles.
    task automatic run_op(input logic [2:0] m, input logic rl, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] c, input int inj1, input int inj2,
                          output logic [63:0] res, output logic sf, output int lat, output int nd);
        nd  = 0;
        lat = -1;
        res = '0;
        sf  = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        op_mode = m;
        relu_en = rl;
        opnd_a  = a;
        opnd_b  = b;
        opnd_c  = c;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) check("busy_after_start", 64'(busy), 64'd1);
            if (done) begin
                nd++;
                if (lat < 0) begin
                    lat = n - 1;
                    res = result;
                    sf  = sat_flag;
                    check("busy_in_done", 64'(busy), 64'd1);
                end
            end
            if (lat >= 0 && n == lat + 2) check("busy_after_done", 64'(busy), 64'd0);
            start   = (n == inj1 || n == inj2);
            op_mode = 3'($urandom);
            relu_en = 1'($urandom);
            opnd_a  = {$urandom, $urandom};
            opnd_b  = {$urandom, $urandom};
            opnd_c  = {$urandom, $urandom};
        end
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] res, exp;
        logic        sf, esf;
        int          lat, nd;
        logic [2:0]  m;
        logic        rl;
        logic [63:0] a, b, c;

        rst = 1'b1; start = 1'b0; op_mode = '0; relu_en = 1'b0;
        opnd_a = '0; opnd_b = '0; opnd_c = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_sat", 64'(sat_flag), 64'd0);
        rst = 1'b0;

        vecs.push_back('{"vadd", TMODE_VADD, 1'b0, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040,
                         64'h0, 64'h0011_0022_0033_0044, 1'b0});
        vecs.push_back('{"vsub_relu", TMODE_VSUB, 1'b1, 64'h0, 64'h0001_0001_0001_0001, 64'h0,
                         64'h0, 1'b0});
        vecs.push_back('{"vsub", TMODE_VSUB, 1'b0, 64'h0, 64'h0001_0001_0001_0001, 64'h0,
                         64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
        vecs.push_back('{"dot", TMODE_DOT, 1'b0, 64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008,
                         64'h0000_0000_0000_000A, 64'd80, 1'b0});
        vecs.push_back('{"dot_wide", TMODE_DOT, 1'b0, 64'h8000_8000_8000_8000,
                         64'h8000_8000_8000_8000, 64'h0000_0000_0000_7FFF, 64'h0000_0001_0000_7FFF, 1'b0});
        vecs.push_back('{"dot_neg", TMODE_DOT, 1'b0, 64'hFFFF_0000_0000_0000, 64'h0002_0000_0000_0000,
                         64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{"dot_neg_relu", TMODE_DOT, 1'b1, 64'hFFFF_0000_0000_0000,
                         64'h0002_0000_0000_0000, 64'h0, 64'h0, 1'b0});
        vecs.push_back('{"vfma", TMODE_VFMA, 1'b0, 64'h0002_0002_0002_0002, 64'h0003_0003_0003_0003,
                         64'h0001_FFFF_0000_FFFA, 64'h0007_0005_0006_0000, 1'b0});
        vecs.push_back('{"vmax", TMODE_VMAX, 1'b0, 64'h8000_0005_FFFF_7FFF, 64'h0001_0004_0000_8000,
                         64'h0, 64'h0001_0005_0000_7FFF, 1'b0});
        vecs.push_back('{"vmax_relu", TMODE_VMAX, 1'b1, 64'hFFFE_0003_FFFE_0003,
                         64'hFFFD_0001_FFFD_0004, 64'h0, 64'h0000_0003_0000_0004, 1'b0});
        vecs.push_back('{"rsvd6", 3'b110, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444,
                         64'h5, 64'h0, 1'b0});
        vecs.push_back('{"rsvd7_relu", 3'b111, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_7FFF_7FFF_7FFF,
                         64'h5, 64'h0, 1'b0});
`ifdef TENSOR_SATURATE_EN
        vecs.push_back('{"vmul", TMODE_VMUL, 1'b0, 64'h0002_0003_FFFF_0100, 64'h0004_0005_0002_0100,
                         64'h0, 64'h0008_000F_FFFE_7FFF, 1'b1});
        vecs.push_back('{"vadd_ovf", TMODE_VADD, 1'b0, 64'h7FFF, 64'h0001, 64'h0, 64'h7FFF, 1'b1});
        vecs.push_back('{"vsub_ovf", TMODE_VSUB, 1'b0, 64'h8000, 64'h0001, 64'h0, 64'h8000, 1'b1});
        vecs.push_back('{"vadd_ovf_relu", TMODE_VADD, 1'b1, 64'h8000, 64'hFFFF, 64'h0, 64'h0, 1'b1});
`else
        vecs.push_back('{"vmul", TMODE_VMUL, 1'b0, 64'h0002_0003_FFFF_0100, 64'h0004_0005_0002_0100,
                         64'h0, 64'h0008_000F_FFFE_0000, 1'b0});
        vecs.push_back('{"vadd_ovf", TMODE_VADD, 1'b0, 64'h7FFF, 64'h0001, 64'h0, 64'h8000, 1'b0});
        vecs.push_back('{"vsub_ovf", TMODE_VSUB, 1'b0, 64'h8000, 64'h0001, 64'h0, 64'h7FFF, 1'b0});
        vecs.push_back('{"vadd_ovf_relu", TMODE_VADD, 1'b1, 64'h8000, 64'hFFFF, 64'h0, 64'h7FFF,
                         1'b0});
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].mode, vecs[i].relu, vecs[i].a, vecs[i].b, vecs[i].c, -1, -1,
                   res, sf, lat, nd);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_sat"}, 64'(sf), 64'(vecs[i].sat));
            check({vecs[i].name, "_latency"}, 64'(lat), 64'(LANES + 1));
            check({vecs[i].name, "_ndone"}, 64'(nd), 64'd1);
        end

        // Extra starts during RUN and in the FINISH cycle must be ignored.
        run_op(TMODE_VADD, 1'b0, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 64'h0, 2, 5,
               res, sf, lat, nd);
        check("dblstart_result", res, 64'h0011_0022_0033_0044);
        check("dblstart_ndone", 64'(nd), 64'd1);
        check("dblstart_latency", 64'(lat), 64'(LANES + 1));

        // Reset in the third RUN cycle aborts the op and clears the previous result.
        @(negedge clk);
        start = 1'b1; op_mode = TMODE_VMAX; relu_en = 1'b0;
        opnd_a = 64'h0001_0002_0003_0004; opnd_b = 64'h0004_0003_0002_0001; opnd_c = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_result", result, 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("rst_mid_no_done", 64'(nd), 64'd0);
        exp = model(TMODE_VMAX, 1'b0, 64'h0001_0002_0003_0004, 64'h0004_0003_0002_0001, 64'h0, esf);
        run_op(TMODE_VMAX, 1'b0, 64'h0001_0002_0003_0004, 64'h0004_0003_0002_0001, 64'h0, -1, -1,
               res, sf, lat, nd);
        check("post_rst_vmax", res, exp);
        check("post_rst_ndone", 64'(nd), 64'd1);

        for (int k = 0; k < 40; k++) begin
            m   = 3'($urandom_range(0, 7));
            rl  = 1'($urandom);
            a   = rand_opnd();
            b   = rand_opnd();
            c   = rand_opnd();
            exp = model(m, rl, a, b, c, esf);
            run_op(m, rl, a, b, c, -1, -1, res, sf, lat, nd);
            check($sformatf("rand%0d_m%0d_result", k, m), res, exp);
            check($sformatf("rand%0d_m%0d_sat", k, m), 64'(sf), 64'(esf));
            check($sformatf("rand%0d_latency", k), 64'(lat), 64'(LANES + 1));
            check($sformatf("rand%0d_ndone", k), 64'(nd), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
